// File: rtl/btb_multi_pkg.sv
// Shared constants and counter helpers for the multi-entry branch target buffer.
// Imported by the table (btb_multi) and the record pipeline (btb_pred_pipe).
package btb_multi_pkg;

    // All-zero hold code means the fetch/execute pipeline advances this cycle.
    localparam int HOLD_CODE_NOPE = 0;
    localparam int MEM_ADDR_ZERO  = 0;

    localparam logic JMP_EN  = 1'b1;
    localparam logic JMP_DIS = 1'b0;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

    function automatic ctr_e ctr_inc(input ctr_e c);
        ctr_e r;
        case (c)
            STRONG_NT: r = WEAK_NT;
            WEAK_NT:   r = WEAK_T;
            default:   r = STRONG_T;
        endcase
        return r;
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        ctr_e r;
        case (c)
            STRONG_T: r = WEAK_T;
            WEAK_T:   r = WEAK_NT;
            default:  r = STRONG_NT;
        endcase
        return r;
    endfunction

    function automatic logic ctr_taken(input ctr_e c);
        return (c == WEAK_T) || (c == STRONG_T);
    endfunction

endpackage

// File: rtl/btb_multi_if.sv
// Signal bundle between the BTB, the PC generator (lookup) and execute (resolution).
// res_valid_i qualifies res_pc_i/res_taken_i/res_target_i; there is no ready, the BTB consumes a resolution in the cycle it is presented.
interface btb_multi_if #(
    parameter int ADDR_W = 32,
    parameter int HOLD_W = 3
);
    logic [HOLD_W-1:0] hold_code_i;
    logic              flush_i;
    logic [ADDR_W-1:0] pc_i;
    logic              jmp_prediction_o;
    logic [ADDR_W-1:0] target_pc_o;
    logic              res_valid_i;
    logic [ADDR_W-1:0] res_pc_i;
    logic              res_taken_i;
    logic [ADDR_W-1:0] res_target_i;
    logic              prediction_error_o;

    modport master (
        output hold_code_i, flush_i, pc_i,
        output res_valid_i, res_pc_i, res_taken_i, res_target_i,
        input  jmp_prediction_o, target_pc_o, prediction_error_o
    );

    modport slave (
        input  hold_code_i, flush_i, pc_i,
        input  res_valid_i, res_pc_i, res_taken_i, res_target_i,
        output jmp_prediction_o, target_pc_o, prediction_error_o
    );
endinterface

// File: rtl/btb_pred_pipe.sv
// PRED_LAT-deep record of {taken, target} predictions, carried from fetch to execute.
// Shifts only on an unheld cycle; flush clears every stage and wins over the shift.
module btb_pred_pipe #(
    parameter int ADDR_W   = 32,
    parameter int PRED_LAT = 1,
    parameter int HOLD_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HOLD_W-1:0] hold_code,
    input  logic              flush,
    input  logic              lookup_taken,
    input  logic [ADDR_W-1:0] lookup_target,
    output logic              rec_taken,
    output logic [ADDR_W-1:0] rec_target
);
    import btb_multi_pkg::*;

    logic [PRED_LAT-1:0] taken_q;
    logic [ADDR_W-1:0]   target_q [PRED_LAT];
    logic                advance;

    assign advance = (hold_code == HOLD_W'(HOLD_CODE_NOPE));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            taken_q <= '0;
            for (int k = 0; k < PRED_LAT; k++) begin
                target_q[k] <= '0;
            end
        end else if (advance) begin
            taken_q[0]  <= lookup_taken;
            target_q[0] <= lookup_target;
            for (int k = 1; k < PRED_LAT; k++) begin
                taken_q[k]  <= taken_q[k-1];
                target_q[k] <= target_q[k-1];
            end
        end
    end

    assign rec_taken  = taken_q[PRED_LAT-1];
    assign rec_target = target_q[PRED_LAT-1];

endmodule

// File: rtl/btb_multi.sv
// Direct-mapped branch target buffer with 2-bit direction counters per entry.
// Predicts combinationally for the fetch PC and trains from execute resolutions.
module btb_multi #(
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 16,
    parameter int PRED_LAT = 1,
    parameter int HOLD_W   = 3
) (
    input logic        clk,
    input logic        rst,
    btb_multi_if.slave bus
);
    import btb_multi_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(MEM_ADDR_ZERO);

    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    logic [ADDR_W-1:0] target_q [DEPTH];
    ctr_e              ctr_q    [DEPTH];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic              lk_taken;
    logic [ADDR_W-1:0] lk_target;

    logic [IDX_W-1:0]  tr_idx;
    logic [TAG_W-1:0]  tr_tag;
    logic              tr_hit;
    logic              advance;
    logic              train_en;

    logic              rec_taken;
    logic [ADDR_W-1:0] rec_target;

    assign advance = (bus.hold_code_i == HOLD_W'(HOLD_CODE_NOPE));

    // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
    always_comb begin
        lk_idx    = bus.pc_i[IDX_W+1:2];
        lk_tag    = bus.pc_i[ADDR_W-1:IDX_W+2];
        lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && (bus.pc_i != ADDR_ZERO);
        lk_taken  = (lk_hit && ctr_taken(ctr_q[lk_idx])) ? JMP_EN : JMP_DIS;
        lk_target = lk_taken ? target_q[lk_idx] : ADDR_ZERO;
    end

    always_comb begin
        tr_idx   = bus.res_pc_i[IDX_W+1:2];
        tr_tag   = bus.res_pc_i[ADDR_W-1:IDX_W+2];
        tr_hit   = valid_q[tr_idx] && (tag_q[tr_idx] == tr_tag);
        train_en = bus.res_valid_i && advance && (bus.res_pc_i != ADDR_ZERO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                tag_q[e]    <= '0;
                target_q[e] <= '0;
                ctr_q[e]    <= WEAK_NT;
            end
        end else if (train_en) begin
            if (tr_hit) begin
                if (bus.res_taken_i) begin
                    ctr_q[tr_idx]    <= ctr_inc(ctr_q[tr_idx]);
                    target_q[tr_idx] <= bus.res_target_i;
                end else begin
                    ctr_q[tr_idx] <= ctr_dec(ctr_q[tr_idx]);
                end
            end else if (bus.res_taken_i) begin
                // Miss on a taken branch replaces whatever lived at this index.
                valid_q[tr_idx]  <= 1'b1;
                tag_q[tr_idx]    <= tr_tag;
                target_q[tr_idx] <= bus.res_target_i;
                ctr_q[tr_idx]    <= WEAK_T;
            end
        end
    end

    btb_pred_pipe #(
        .ADDR_W   (ADDR_W),
        .PRED_LAT (PRED_LAT),
        .HOLD_W   (HOLD_W)
    ) u_pred_pipe (
        .clk           (clk),
        .rst           (rst),
        .hold_code     (bus.hold_code_i),
        .flush         (bus.flush_i),
        .lookup_taken  (lk_taken),
        .lookup_target (lk_target),
        .rec_taken     (rec_taken),
        .rec_target    (rec_target)
    );

    assign bus.jmp_prediction_o   = lk_taken;
    assign bus.target_pc_o        = lk_target;
    assign bus.prediction_error_o = bus.res_valid_i &&
        ((bus.res_taken_i != rec_taken) ||
         (bus.res_taken_i && (rec_target != bus.res_target_i)));

endmodule

// File: tb/tb_btb_multi.sv
// Randomised scoreboard bench for btb_multi against a table/queue reference model.
// The driver pushes expected outputs per cycle; a negedge monitor pops and compares.
module tb_btb_multi;

    localparam int AW    = 32;
    localparam int HW    = 3;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int W     = AW + 2;

    typedef struct packed {
        logic          taken;
        logic [AW-1:0] target;
        logic [AW-1:0] pc;
    } rec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_multi_if #(.ADDR_W(AW), .HOLD_W(HW)) bus ();

    btb_multi #(
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .PRED_LAT (LAT),
        .HOLD_W   (HW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    logic          m_valid [DEPTH];
    logic [AW-1:0] m_tag   [DEPTH];
    logic [AW-1:0] m_tgt   [DEPTH];
    int            m_ctr   [DEPTH];
    rec_t          rec_q[$];

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        rec_q.delete();
        for (int i = 0; i < LAT; i++) rec_q.push_back('0);
    endfunction

    function automatic void model_lookup(input logic [AW-1:0] pc, output logic p, output logic [AW-1:0] t);
        int i;
        i = int'((pc >> 2) % DEPTH);
        p = (pc != 0) && m_valid[i] && (m_tag[i] == (pc >> (2 + IDX_W))) && (m_ctr[i] >= 2);
        t = p ? m_tgt[i] : '0;
    endfunction

    function automatic void model_train(input logic [AW-1:0] rpc, input logic rt, input logic [AW-1:0] rtgt);
        int  i;
        logic hit;
        i   = int'((rpc >> 2) % DEPTH);
        hit = m_valid[i] && (m_tag[i] == (rpc >> (2 + IDX_W)));
        if (hit && rt) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = rtgt;
        end else if (hit) begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (rt) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = rpc >> (2 + IDX_W);
            m_tgt[i]   = rtgt;
            m_ctr[i]   = 2;
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("jmp_prediction", AW'(bus.jmp_prediction_o), AW'(e[AW+1]));
            chk("target_pc", bus.target_pc_o, e[AW:1]);
            chk("prediction_error", AW'(bus.prediction_error_o), AW'(e[0]));
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic [HW-1:0] hold, input logic fl,
                        input logic [AW-1:0] pc, input logic rv, input logic [AW-1:0] rpc,
                        input logic rt, input logic [AW-1:0] rtgt);
        logic          p;
        logic [AW-1:0] t;
        logic          e;
        rec_t          fin;
        rst              = r;
        bus.hold_code_i  = hold;
        bus.flush_i      = fl;
        bus.pc_i         = pc;
        bus.res_valid_i  = rv;
        bus.res_pc_i     = rpc;
        bus.res_taken_i  = rt;
        bus.res_target_i = rtgt;
        model_lookup(pc, p, t);
        fin = rec_q[LAT-1];
        e   = rv && ((rt != fin.taken) || (rt && (fin.target != rtgt)));
        exp_q.push_back({p, t, e});
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (rv && (hold == 0) && (rpc != 0)) model_train(rpc, rt, rtgt);
            if (fl) begin
                foreach (rec_q[k]) rec_q[k] = '0;
            end else if (hold == 0) begin
                rec_q.push_front('{taken: p, target: t, pc: pc});
                void'(rec_q.pop_back());
            end
        end
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] pc);
        step(1'b0, '0, 1'b0, pc, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic resolve(input logic [AW-1:0] pc, input logic [AW-1:0] rpc,
                           input logic rt, input logic [AW-1:0] rtgt);
        step(1'b0, '0, 1'b0, pc, 1'b1, rpc, rt, rtgt);
    endtask

    function automatic logic [AW-1:0] rand_pc();
        return (AW'($urandom_range(0, 255)) << 2) | AW'($urandom_range(0, 3));
    endfunction

    function automatic logic [AW-1:0] rand_tgt();
        return AW'($urandom_range(1, 4)) << 8;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bus.hold_code_i  = '0;
        bus.flush_i      = 1'b0;
        bus.pc_i         = '0;
        bus.res_valid_i  = 1'b0;
        bus.res_pc_i     = '0;
        bus.res_taken_i  = 1'b0;
        bus.res_target_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // First resolution allocates the entry, next lookup hits.
        fetch(32'h100);
        fetch(32'h0);
        resolve(32'h100, 32'h100, 1'b1, 32'h200);
        fetch(32'h100);

        // Saturation up, hysteresis and saturation down.
        repeat (4) resolve(32'h100, 32'h100, 1'b1, 32'h200);
        resolve(32'h100, 32'h100, 1'b0, 32'h0);
        fetch(32'h100);
        resolve(32'h100, 32'h100, 1'b0, 32'h0);
        fetch(32'h100);
        repeat (2) resolve(32'h100, 32'h100, 1'b0, 32'h0);
        fetch(32'h100);

        // Aliasing on the same index with a different tag.
        repeat (2) resolve(32'h0, 32'h100, 1'b1, 32'h200);
        resolve(32'h0, 32'h140, 1'b1, 32'h300);
        fetch(32'h100);
        fetch(32'h140);

        // Target change on a strongly-taken entry.
        repeat (3) resolve(32'h0, 32'h100, 1'b1, 32'h200);
        fetch(32'h100);
        fetch(32'h0);
        resolve(32'h100, 32'h100, 1'b1, 32'h280);
        fetch(32'h100);

        // Hold keeps the record, then a matching resolution is correct.
        repeat (2) resolve(32'h0, 32'h180, 1'b1, 32'h380);
        fetch(32'h180);
        repeat (3) step(1'b0, 3'd1, 1'b0, 32'h180, 1'b0, '0, 1'b0, '0);
        fetch(32'h0);
        resolve(32'h0, 32'h180, 1'b1, 32'h380);
        // Flush kills the record, so the same resolution now mispredicts.
        fetch(32'h180);
        step(1'b0, '0, 1'b1, 32'h0, 1'b0, '0, 1'b0, '0);
        fetch(32'h0);
        resolve(32'h0, 32'h180, 1'b1, 32'h380);

        // Index 0: same-cycle update and lookup, and res_pc of zero.
        resolve(32'h040, 32'h040, 1'b1, 32'h500);
        fetch(32'h040);
        resolve(32'h0, 32'h0, 1'b1, 32'h600);
        fetch(32'h0);
        fetch(32'h040);

        // Mid-run reset discards table and records.
        step(1'b1, '0, 1'b0, 32'h040, 1'b1, 32'h040, 1'b1, 32'h700);
        step(1'b1, '0, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h700);
        fetch(32'h040);
        fetch(32'h100);

        for (int c = 0; c < 800; c++) begin
            logic          r, fl, rv, rt;
            logic [HW-1:0] h;
            logic [AW-1:0] pc, rpc, tg;
            r   = ($urandom_range(0, 149) == 0);
            h   = ($urandom_range(0, 4) == 0) ? HW'($urandom_range(1, 7)) : '0;
            fl  = ($urandom_range(0, 19) == 0);
            pc  = ($urandom_range(0, 2) == 0) ? rec_q[LAT-1].pc : rand_pc();
            rv  = ($urandom_range(0, 2) != 0);
            rpc = ($urandom_range(0, 3) != 0) ? rec_q[LAT-1].pc : rand_pc();
            rt  = 1'($urandom_range(0, 1));
            tg  = (rec_q[LAT-1].taken && $urandom_range(0, 3) != 0) ? rec_q[LAT-1].target : rand_tgt();
            step(r, h, fl, pc, rv, rpc, rt, tg);
        end

        bus.res_valid_i = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
